// File: rtl/fma_acc_sequencer_if.sv
// fma_acc_sequencer_if: operand-pair input stream and dot-product result stream
interface fma_acc_sequencer_if #(
    parameter int FP_W  = 16,
    parameter int CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [FP_W-1:0]  i_a;
    logic [FP_W-1:0]  i_b;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [FP_W-1:0]  o_result;
    logic [CNT_W-1:0] o_count;

    modport slave (
        input  i_valid, i_a, i_b, i_last, i_ready,
        output o_ready, o_valid, o_result, o_count
    );

    modport master (
        output i_valid, i_a, i_b, i_last, i_ready,
        input  o_ready, o_valid, o_result, o_count
    );
endinterface

// File: rtl/fma_acc_sequencer.sv
// fma_acc_sequencer: feeds (a, b, acc) to an external FMA and accumulates a dot product
module fma_acc_sequencer #(
    parameter int FP_W  = 16,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    fma_acc_sequencer_if.slave  bus,
    output logic [FP_W-1:0]     o_fma_a,
    output logic [FP_W-1:0]     o_fma_b,
    output logic [FP_W-1:0]     o_fma_c,
    output logic                o_fma_msel,
    output logic                o_fma_pipeline_en,
    input  logic [FP_W-1:0]     i_fma_result
);
    localparam int LW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [FP_W-1:0]  r_acc, r_result;
    logic [CNT_W-1:0] r_cnt, r_count, w_cnt_inc;
    logic [LW-1:0]    r_lat_ctr;
    logic             r_first, r_last, r_valid;
    logic             w_ready, w_en, w_hs_in, w_fire, w_hs_out;

    assign bus.o_ready       = w_ready;
    assign bus.o_valid       = r_valid;
    assign bus.o_result      = r_result;
    assign bus.o_count       = r_count;
    assign o_fma_pipeline_en = w_en;

    // State register; clear aborts any in-flight work
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) r_state <= S_IDLE;
        else                  r_state <= w_next;
    end

    // Next state and handshake/enable decode, all derived from the current state
    always_comb begin
        w_ready   = (r_state == S_IDLE);
        w_en      = (r_state == S_EXEC);
        w_hs_in   = w_ready & bus.i_valid;
        w_fire    = w_en & (r_lat_ctr == '0);
        w_hs_out  = (r_state == S_DONE) & r_valid & bus.i_ready;
        w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        w_next    = w_hs_in  ? S_EXEC :
                    w_fire   ? (r_last ? S_DONE : S_IDLE) :
                    w_hs_out ? S_IDLE : r_state;
    end

    // Operand issue, latency countdown, accumulator writeback and result hold
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc      <= '0;
            r_first    <= 1'b1;
            r_cnt      <= '0;
            r_lat_ctr  <= '0;
            r_last     <= 1'b0;
            o_fma_a    <= '0;
            o_fma_b    <= '0;
            o_fma_c    <= '0;
            o_fma_msel <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_count    <= '0;
        end else begin
            if (w_hs_in) begin
                o_fma_a    <= bus.i_a;
                o_fma_b    <= bus.i_b;
                o_fma_c    <= r_first ? '0 : r_acc;
                o_fma_msel <= (bus.i_a[FP_W-2:0] == '0) | (bus.i_b[FP_W-2:0] == '0);
                r_last     <= bus.i_last;
                r_lat_ctr  <= LW'(LAT);
            end
            if (w_en && r_lat_ctr != '0) r_lat_ctr <= r_lat_ctr - LW'(1);
            if (w_fire) begin
                r_acc   <= i_fma_result;
                r_first <= 1'b0;
                r_cnt   <= w_cnt_inc;
                if (r_last) begin
                    r_result <= i_fma_result;
                    r_count  <= w_cnt_inc;
                    r_valid  <= 1'b1;
                end
            end
            if (w_hs_out) begin
                r_valid <= 1'b0;
                r_first <= 1'b1;
                r_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fma_acc_sequencer.sv
// tb_fma_acc_sequencer: randomized and directed checks against a real-valued dot-product model
module tb_fma_acc_sequencer;
    localparam int FP_W  = 16;
    localparam int LAT   = 1;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, clear;
    logic [FP_W-1:0]  fma_a, fma_b, fma_c, fma_result, fma_f;
    logic             fma_msel, fma_en;
    int               n_checks = 0;
    int               n_fail = 0;
    real              m_sum;
    int               m_cnt;
    bit               m_first;
    logic [FP_W-1:0]  last_result;
    logic [CNT_W-1:0] last_count;
    logic [FP_W-1:0]  vals [9] = '{16'h0000, 16'h3C00, 16'hBC00, 16'h4000, 16'h3800,
                                   16'h4200, 16'h3E00, 16'h8000, 16'hC000};

    fma_acc_sequencer_if #(.FP_W(FP_W), .CNT_W(CNT_W)) bus ();

    fma_acc_sequencer #(.FP_W(FP_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .bus(bus),
        .o_fma_a(fma_a), .o_fma_b(fma_b), .o_fma_c(fma_c),
        .o_fma_msel(fma_msel), .o_fma_pipeline_en(fma_en),
        .i_fma_result(fma_result)
    );

    always #5 clk = ~clk;

    function automatic real fp2real(input logic [15:0] x);
        real v;
        int  e;
        e = int'(x[14:10]);
        if (e == 0) v = real'(x[9:0]) * 5.9604644775390625e-8;
        else begin
            v = 1.0 + real'(x[9:0]) / 1024.0;
            for (int i = 0; i < e - 15; i++) v = v * 2.0;
            for (int i = 0; i < 15 - e; i++) v = v / 2.0;
        end
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real2fp(input real v);
        logic s;
        real  m;
        int   e, f;
        if (v == 0.0) return 16'h0000;
        s = v < 0.0;
        m = s ? -v : v;
        if (m < 6.103515625e-5) return {s, 5'd0, 10'($rtoi(m * 16777216.0 + 0.5))};
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        f = $rtoi((m - 1.0) * 1024.0 + 0.5);
        return {s, 5'(e + 15), 10'(f)};
    endfunction

    // Behavioural FMA with LAT enabled pipeline stages
    assign fma_f = fma_msel ? fma_c : real2fp(fp2real(fma_a) * fp2real(fma_b) + fp2real(fma_c));
    generate
        if (LAT == 0) begin : g_comb
            assign fma_result = fma_f;
        end else begin : g_pipe
            logic [FP_W-1:0] pipe [LAT];
            always @(posedge clk) if (fma_en) begin
                pipe[0] <= fma_f;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign fma_result = pipe[LAT-1];
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sum = 0.0;
        m_cnt = 0;
        m_first = 1'b1;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        logic [15:0] exp_c;
        logic        exp_msel;
        int          w;
        exp_c    = m_first ? 16'h0000 : real2fp(m_sum);
        exp_msel = (a[14:0] == 15'd0) || (b[14:0] == 15'd0);
        m_sum    = m_sum + fp2real(a) * fp2real(b);
        m_cnt++;
        m_first  = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_last = last;
        w = 0;
        while (!bus.o_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        bus.i_a = $urandom;
        bus.i_b = $urandom;
        @(negedge clk);
        check("fma_a", fma_a, a);
        check("fma_b", fma_b, b);
        check("fma_c", fma_c, exp_c);
        check("msel", fma_msel, exp_msel);
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("msel_hold", fma_msel, exp_msel);
                check("a_hold", fma_a, a);
            end
            check("exec_en", fma_en, 1);
            check("exec_ready", bus.o_ready, 0);
            check("exec_valid", bus.o_valid, 0);
        end
        @(negedge clk);
        check("post_en", fma_en, 0);
        if (last) begin
            check("o_valid", bus.o_valid, 1);
            check("o_result", bus.o_result, real2fp(m_sum));
            check("o_count", bus.o_count, (m_cnt > CMAX) ? CMAX : m_cnt);
            last_result = bus.o_result;
            last_count = bus.o_count;
        end else begin
            check("next_ready", bus.o_ready, 1);
        end
    endtask

    task automatic take_result(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check("bp_valid", bus.o_valid, 1);
            check("bp_result", bus.o_result, last_result);
            check("bp_count", bus.o_count, last_count);
            check("bp_ready", bus.o_ready, 0);
            check("bp_en", fma_en, 0);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check("out_valid_drop", bus.o_valid, 0);
        check("out_idle_ready", bus.o_ready, 1);
        model_reset();
    endtask

    task automatic dot(input int n, input int hold);
        for (int i = 0; i < n; i++)
            send_pair(vals[$urandom_range(0, 8)], vals[$urandom_range(0, 8)], i == n - 1);
        take_result(hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_last = 1'b0;
        bus.i_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_result", bus.o_result, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_en", fma_en, 0);
        check("rst_fma_c", fma_c, 0);

        send_pair(16'h3C00, 16'h4000, 1'b0);
        send_pair(16'h4000, 16'h4200, 1'b1);
        take_result(5);
        check("tp_dot8", last_result, 16'h4800);
        check("tp_cnt2", last_count, 2);

        send_pair(16'h8000, 16'h4200, 1'b1);
        take_result(0);
        check("tp_negzero", last_result, 16'h0000);
        send_pair(16'h3C00, 16'h0001, 1'b1);
        take_result(1);
        check("tp_subnorm", last_result, 16'h0001);

        send_pair(16'h3C00, 16'h3C00, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_a = 16'h4000;
        bus.i_b = 16'h4000;
        bus.i_last = 1'b0;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (LAT > 0 ? 2 : 1) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clr_ready", bus.o_ready, 1);
        check("clr_valid", bus.o_valid, 0);
        check("clr_fma_c", fma_c, 0);
        check("clr_fma_a", fma_a, 0);
        repeat (LAT + 3) @(negedge clk);
        check("clr_no_valid", bus.o_valid, 0);
        model_reset();
        send_pair(16'h4000, 16'h4000, 1'b1);
        take_result(0);
        check("tp_after_clr", last_result, 16'h4400);
        check("tp_after_clr_cnt", last_count, 1);

        for (int i = 0; i < 260; i++) send_pair(16'h3C00, 16'h3C00, i == 259);
        take_result(2);
        check("sat_result", last_result, 16'h5C10);
        check("sat_count", last_count, CMAX);

        for (int t = 0; t < 40; t++) dot($urandom_range(1, 6), $urandom_range(0, 3));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
